// File: rtl/seg_scan_display.sv
// Time-multiplexed, active-low 7-segment hex display driver with blink on the pending operand digit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg_scan_display #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4*N-1:0] values_flat,
  input  logic           sel_valid,
  input  logic [3:0]     sel_index,
  output logic [N-1:0]   an,
  output logic [6:0]     seg,
  output logic           dp
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned DW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_digit;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [N-1:0]  r_an;
  logic [6:0]    r_seg;

  logic          w_presc_tc;
  logic          w_digit_tc;
  logic          w_frame_tc;
  logic [3:0]    w_val;
  logic [6:0]    w_seg_dec;
  logic [6:0]    w_seg_nx;
  logic [N-1:0]  w_an_nx;
  logic          w_hide;

  assign w_presc_tc = (r_presc == PW'(CLK_DIV - 1));
  assign w_digit_tc = (r_digit == DW'(N - 1));
  assign w_frame_tc = (r_frame == FW'(BLINK_FRAMES - 1));
  assign w_val      = values_flat[{r_digit, 2'b00} +: 4];

  // Hex decode, segments {g,f,e,d,c,b,a}, active-low
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_val)
      4'h0: w_seg_dec = 7'b1000000;
      4'h1: w_seg_dec = 7'b1111001;
      4'h2: w_seg_dec = 7'b0100100;
      4'h3: w_seg_dec = 7'b0110000;
      4'h4: w_seg_dec = 7'b0011001;
      4'h5: w_seg_dec = 7'b0010010;
      4'h6: w_seg_dec = 7'b0000010;
      4'h7: w_seg_dec = 7'b1111000;
      4'h8: w_seg_dec = 7'b0000000;
      4'h9: w_seg_dec = 7'b0010000;
      4'hA: w_seg_dec = 7'b0001000;
      4'hB: w_seg_dec = 7'b0000011;
      4'hC: w_seg_dec = 7'b1000110;
      4'hD: w_seg_dec = 7'b0100001;
      4'hE: w_seg_dec = 7'b0000110;
      4'hF: w_seg_dec = 7'b0001110;
      default: w_seg_dec = 7'h7F;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_hi_zero;

  // Blank when this digit and every higher-index digit are zero
  always_comb begin
    w_hi_zero = 1'b1;
    for (int k = 0; k < int'(N); k++) begin
      if (k >= int'(r_digit) && values_flat[4*k +: 4] != 4'h0) w_hi_zero = 1'b0;
    end
    w_seg_nx = (r_digit != '0 && w_hi_zero) ? 7'h7F : w_seg_dec;
  end
`else
  assign w_seg_nx = w_seg_dec;
`endif

  // Indices >= N never equal the digit counter, so they never blink
  assign w_hide  = sel_valid && r_blink && (sel_index == 4'(r_digit));
  assign w_an_nx = w_hide ? '1 : ~(N'(1) << r_digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= '0;
      r_frame <= '0;
      r_blink <= 1'b0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
    end else begin
      r_an  <= w_an_nx;
      r_seg <= w_seg_nx;
      if (w_presc_tc) begin
        r_presc <= '0;
        if (w_digit_tc) begin
          r_digit <= '0;
          if (w_frame_tc) begin
            r_frame <= '0;
            r_blink <= ~r_blink;
          end else begin
            r_frame <= r_frame + FW'(1);
          end
        end else begin
          r_digit <= r_digit + DW'(1);
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = 1'b1;

endmodule
